// File: rtl/instr_fetch_pkg.sv
// Shared types and constants for the instruction fetch sequencer.
package instr_fetch_pkg;

    localparam int unsigned WORD_BYTES = 4;
    localparam int unsigned XLEN       = 32;

    typedef enum logic {
        RUN  = 1'b0,
        HALT = 1'b1
    } fetch_state_e;

    typedef struct packed {
        logic [XLEN-1:0] instr;
        logic [XLEN-1:0] pc;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// Two-entry first-word-fall-through queue of fetched instructions toward decode.
module fetch_fifo
    import instr_fetch_pkg::*;
(
    input  logic         clk,
    input  logic         rst,
    input  logic         push,
    input  fetch_entry_t push_data,
    input  logic         pop,
    input  logic         flush,
    output logic [1:0]   count,
    output logic         valid,
    output fetch_entry_t head
);

    localparam int unsigned DEPTH = 2;

    fetch_entry_t entries [DEPTH];
    logic         rd_ptr;
    logic         wr_ptr;
    logic         do_pop;

    assign valid  = (count != 2'd0);
    assign do_pop = pop && valid;
    assign head   = entries[rd_ptr];

    // Flush drops all entries; push and pop may coincide.
    always_ff @(posedge clk) begin
        if (rst) begin
            entries[0] <= '0;
            entries[1] <= '0;
            rd_ptr     <= 1'b0;
            wr_ptr     <= 1'b0;
            count      <= 2'd0;
        end else if (flush) begin
            rd_ptr <= 1'b0;
            wr_ptr <= 1'b0;
            count  <= 2'd0;
        end else begin
            if (push) begin
                entries[wr_ptr] <= push_data;
                wr_ptr          <= ~wr_ptr;
            end
            if (do_pop) begin
                rd_ptr <= ~rd_ptr;
            end
            count <= count + 2'(push) - 2'(do_pop);
        end
    end

    // The issue throttle in the parent guarantees room for every response.
    no_overflow: assert property (@(posedge clk) disable iff (rst || flush)
        !(push && (count == 2'(DEPTH)) && !do_pop));

endmodule

// File: rtl/instr_fetch_ctrl.sv
// Fetch sequencer: owns the fetch PC, issues reads to a 1-cycle instruction
// memory and queues returned {instr, pc} toward decode.
module instr_fetch_ctrl
    import instr_fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC  = 32'd0,
    parameter int unsigned MEM_WORDS = 32
)
(
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        redirect_i,
    input  logic [31:0] redirect_pc_i,
    output logic        mem_req_o,
    output logic [31:0] mem_addr_o,
    input  logic [31:0] mem_instr_i,
    output logic        instr_valid_o,
    output logic [31:0] instr_o,
    output logic [31:0] instr_pc_o,
    input  logic        instr_ready_i,
    output logic        fault_o
);

    localparam logic [31:0] LAST_ADDR = 32'(WORD_BYTES * MEM_WORDS - WORD_BYTES);
    localparam logic [31:0] PC_STEP   = 32'(WORD_BYTES);
    localparam int unsigned QDEPTH    = 2;

    fetch_state_e state;
    logic [31:0]  fetch_pc;
    logic [31:0]  resp_pc;
    logic         inflight;
    logic [1:0]   count;
    logic         pc_bad;
    logic         pop;
    logic         push;
    logic         issue;
    fetch_entry_t push_entry;
    fetch_entry_t head;

    assign pc_bad = (fetch_pc[1:0] != 2'b00) || (fetch_pc > LAST_ADDR);
    assign pop    = instr_valid_o && instr_ready_i;

    // Only issue when the slot is guaranteed free by the time data returns.
    assign issue = !rst_i && (state == RUN) && !pc_bad && !redirect_i &&
                   ((3'(count) + 3'(inflight)) < (3'(QDEPTH) + 3'(pop)));

    // A redirect or reset in the response cycle kills the returning word.
    assign push = inflight && !redirect_i && !rst_i;

    assign push_entry.instr = mem_instr_i;
    assign push_entry.pc    = resp_pc;

    assign mem_req_o  = issue;
    assign mem_addr_o = fetch_pc;

    assign instr_o    = head.instr;
    assign instr_pc_o = head.pc;
    assign fault_o    = (state == HALT);

    // PC, in-flight tracking and RUN/HALT control.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state    <= RUN;
            fetch_pc <= RESET_PC;
            resp_pc  <= '0;
            inflight <= 1'b0;
        end else if (redirect_i) begin
            state    <= RUN;
            fetch_pc <= redirect_pc_i;
            inflight <= 1'b0;
        end else begin
            inflight <= issue;
            if (issue) begin
                fetch_pc <= fetch_pc + PC_STEP;
                resp_pc  <= fetch_pc;
            end
            if ((state == RUN) && pc_bad) begin
                state <= HALT;
            end
        end
    end

    fetch_fifo u_fifo (
        .clk       (clk_i),
        .rst       (rst_i),
        .push      (push),
        .push_data (push_entry),
        .pop       (pop),
        .flush     (redirect_i),
        .count     (count),
        .valid     (instr_valid_o),
        .head      (head)
    );

endmodule
